// File: rtl/program_counter.sv
// Fetch-stage next-PC selection and PC register for the RV32I core.
// Optional feature macro: PC_MISALIGN_CHECK_EN adds the misaligned output and blocks misaligned loads.
module program_counter #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_en,
    input  logic [1:0]      pc_source,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc_out
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic            misaligned
`endif
);

    localparam logic [XLEN-1:0] ONE       = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] FOUR      = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] pc_rs1;
    logic [XLEN-1:0] pc_immed;
    logic [XLEN-1:0] pc_plus4;
    logic            branch_taken;
    logic            load;

    assign pc_rs1       = rs1_data + immediate;
    assign pc_immed     = pc_in + immediate;
    assign pc_plus4     = pc_in + FOUR;
    assign branch_taken = (alu_result == ONE);

    always_comb begin
        pc_next = pc_plus4;
        unique case (pc_source)
            2'b00: pc_next = pc_rs1 & LSB_CLEAR;
            2'b01: pc_next = pc_immed;
            2'b10: pc_next = branch_taken ? pc_immed : pc_plus4;
            2'b11: pc_next = pc_plus4;
        endcase
    end

`ifdef PC_MISALIGN_CHECK_EN
    // Misaligned targets are left for the trap handler to redirect; the PC keeps its value.
    assign misaligned = (pc_next[1:0] != 2'b00);
    assign load       = pc_en && !misaligned;
`else
    assign load       = pc_en;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_out <= RESET_VECTOR;
        end else if (load) begin
            pc_out <= pc_next;
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed vectors plus randomized traffic
// against an arithmetic reference model of the next-PC rules.
module tb_program_counter;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        pc_en;
    logic [1:0]  pc_source;
    logic [31:0] rs1_data;
    logic [31:0] immediate;
    logic [31:0] alu_result;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic [31:0] pc_out;
`ifdef PC_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    int tests_run;
    int tests_failed;
    logic [31:0] model_pc;

    program_counter #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_en      (pc_en),
        .pc_source  (pc_source),
        .rs1_data   (rs1_data),
        .immediate  (immediate),
        .alu_result (alu_result),
        .pc_in      (pc_in),
        .pc_next    (pc_next),
        .pc_out     (pc_out)
`ifdef PC_MISALIGN_CHECK_EN
        ,
        .misaligned (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [1:0] src, input logic [31:0] rs1,
                                             input logic [31:0] imm, input logic [31:0] alu,
                                             input logic [31:0] pc);
        longint unsigned sum;
        case (src)
            2'd0: begin
                sum = (longint'(rs1) + longint'(imm)) % 64'h1_0000_0000;
                return 32'(sum - (sum % 2));
            end
            2'd1: return 32'((longint'(pc) + longint'(imm)) % 64'h1_0000_0000);
            2'd2: begin
                if (alu == 32'd1) return 32'((longint'(pc) + longint'(imm)) % 64'h1_0000_0000);
                return 32'((longint'(pc) + 4) % 64'h1_0000_0000);
            end
            default: return 32'((longint'(pc) + 4) % 64'h1_0000_0000);
        endcase
    endfunction

    // Drive one cycle of inputs, check the combinational result, then the registered one.
    task automatic step(input string tag, input logic rst, input logic en, input logic [1:0] src,
                        input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] alu,
                        input logic [31:0] pc);
        logic [31:0] exp_next;
        logic        exp_mis;
        rst_n = rst; pc_en = en; pc_source = src;
        rs1_data = rs1; immediate = imm; alu_result = alu; pc_in = pc;
        exp_next = ref_next(src, rs1, imm, alu, pc);
        exp_mis  = (exp_next % 4) != 0;
        #1;
        check({tag, ".next"}, pc_next, exp_next);
`ifdef PC_MISALIGN_CHECK_EN
        check({tag, ".mis"}, {31'd0, misaligned}, {31'd0, exp_mis});
        if (rst && en && exp_mis) model_pc = model_pc;
        else if (!rst) model_pc = RV;
        else if (en) model_pc = exp_next;
`else
        if (!rst) model_pc = RV;
        else if (en) model_pc = exp_next;
`endif
        @(posedge clk);
        #1;
        check({tag, ".out"}, pc_out, model_pc);
    endtask

    initial begin
        logic [31:0] alu;
        tests_run    = 0;
        tests_failed = 0;
        model_pc     = 32'hDEAD_BEEF;
        rst_n = 1'b0; pc_en = 1'b0; pc_source = 2'b11;
        rs1_data = '0; immediate = '0; alu_result = '0; pc_in = '0;
        @(posedge clk);
        #1;

        step("reset",    1'b0, 1'b1, 2'b11, 32'h2000, 32'h10, 32'h0, 32'h1000);
        check("reset_val", pc_out, 32'h0);
        step("jalr",     1'b1, 1'b1, 2'b00, 32'h2000, 32'h10, 32'h0, 32'h1000);
        check("jalr_abs", pc_out, 32'h2010);
        step("jalr_lsb", 1'b1, 1'b1, 2'b00, 32'h2001, 32'h0,  32'h0, 32'h1000);
        check("jalr_lsb_abs", pc_next, 32'h2000);
        step("jal",      1'b1, 1'b1, 2'b01, 32'h2000, 32'h10, 32'h0, 32'h1000);
        check("jal_abs", pc_out, 32'h1010);
        step("jal_neg",  1'b1, 1'b1, 2'b01, 32'h2000, 32'hFFFF_FFF0, 32'h0, 32'h1000);
        check("jal_neg_abs", pc_out, 32'h0FF0);
        step("br_t",     1'b1, 1'b1, 2'b10, 32'h2000, 32'h10, 32'h1, 32'h1000);
        check("br_t_abs", pc_out, 32'h1010);
        step("br_nt0",   1'b1, 1'b1, 2'b10, 32'h2000, 32'h10, 32'h0, 32'h1000);
        check("br_nt0_abs", pc_out, 32'h1004);
        step("br_nt2",   1'b1, 1'b1, 2'b10, 32'h2000, 32'h10, 32'h2, 32'h1000);
        check("br_nt2_abs", pc_out, 32'h1004);
        step("br_ntff",  1'b1, 1'b1, 2'b10, 32'h2000, 32'h10, 32'hFFFF_FFFF, 32'h1000);
        step("seq",      1'b1, 1'b1, 2'b11, 32'h2000, 32'h10, 32'h0, 32'h1000);
        check("seq_abs", pc_out, 32'h1004);
        step("seq_wrap", 1'b1, 1'b1, 2'b11, 32'h2000, 32'h10, 32'h0, 32'hFFFF_FFFC);
        check("seq_wrap_abs", pc_out, 32'h0);
        step("load",     1'b1, 1'b1, 2'b01, 32'h2000, 32'h10, 32'h0, 32'h1000);
        for (int i = 0; i < 3; i++)
            step("hold", 1'b1, 1'b0, 2'b11, 32'h2000, 32'h10, 32'h0, 32'h1000);
        check("hold_abs", pc_out, 32'h1010);
        step("rst_mid",  1'b0, 1'b1, 2'b11, 32'h2000, 32'h10, 32'h0, 32'h1000);
        check("rst_mid_abs", pc_out, RV);
`ifdef PC_MISALIGN_CHECK_EN
        step("pre_mis",  1'b1, 1'b1, 2'b01, 32'h2000, 32'h10, 32'h0, 32'h1000);
        step("mis",      1'b1, 1'b1, 2'b01, 32'h2000, 32'h2,  32'h0, 32'h1000);
        check("mis_abs", pc_out, 32'h1010);
`endif

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: alu = 32'd1;
                1: alu = 32'd0;
                2: alu = 32'd2;
                default: alu = $urandom;
            endcase
            step("rand", ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
                 alu,
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
